// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B using one multiply-accumulate unit; elements are produced in row-major order.
// Define MATMUL_SAT_EN to clamp c_wdata to 2^bitlength-1 instead of truncating it modulo 2^bitlength.
module matmul_seq_ctrl #(
    parameter  int bitlength = 8,
    parameter  int M1_D1     = 4,
    parameter  int M1_D2     = 2,
    parameter  int M2_D2     = 3,
    localparam int RW        = (M1_D1 > 1) ? $clog2(M1_D1) : 1,
    localparam int KW        = (M1_D2 > 1) ? $clog2(M1_D2) : 1,
    localparam int CW        = (M2_D2 > 1) ? $clog2(M2_D2) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    output logic [RW-1:0]        a_row,
    output logic [KW-1:0]        a_col,
    input  logic [bitlength-1:0] a_rdata,
    output logic [KW-1:0]        b_row,
    output logic [CW-1:0]        b_col,
    input  logic [bitlength-1:0] b_rdata,
    output logic                 c_we,
    output logic [RW-1:0]        c_row,
    output logic [CW-1:0]        c_col,
    output logic [bitlength-1:0] c_wdata,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start, all outputs 0
    // MAC   | accumulating A[i][k]*B[k][j], one k per cycle
    // WRITE | C[i][j] = acc presented with c_we for one cycle
    // DONE  | one-cycle done pulse, start ignored
    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    localparam int AW = 2*bitlength + $clog2(M1_D2);
    localparam logic [RW-1:0] I_LAST = RW'(M1_D1 - 1);
    localparam logic [KW-1:0] K_LAST = KW'(M1_D2 - 1);
    localparam logic [CW-1:0] J_LAST = CW'(M2_D2 - 1);

    state_t                 state_q, state_d;
    logic [RW-1:0]          i_q, i_d;
    logic [CW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [2*bitlength-1:0] prod;
    logic [bitlength-1:0]   c_val;

    assign prod = a_rdata * b_rdata;

`ifdef MATMUL_SAT_EN
    assign c_val = (acc_q[AW-1:bitlength] != '0) ? {bitlength{1'b1}} : acc_q[bitlength-1:0];
`else
    assign c_val = acc_q[bitlength-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_row   = '0;
        a_col   = '0;
        b_row   = '0;
        b_col   = '0;
        c_we    = 1'b0;
        c_row   = '0;
        c_col   = '0;
        c_wdata = '0;
        done    = 1'b0;
        busy    = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start && !stall) begin
                    state_d = MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            MAC: begin
                a_row = i_q;
                a_col = k_q;
                b_row = k_q;
                b_col = j_q;
                if (!stall) begin
                    acc_d = (k_q == '0) ? AW'(prod) : acc_q + AW'(prod);
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = WRITE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                c_row   = i_q;
                c_col   = j_q;
                c_wdata = c_val;
                c_we    = !stall;
                if (!stall) begin
                    state_d = MAC;
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (i_q == I_LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done = !stall;
                if (!stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: expected C writes are queued when a pass is started
// and compared in order as c_we pulses; done timing, stall and reset behaviour are checked too.
module tb_matmul_seq_ctrl;

    localparam int D1 = 4;
    localparam int D2 = 2;
    localparam int D3 = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, stall;
    logic [1:0] a_row;
    logic       a_col;
    logic [7:0] a_rdata;
    logic       b_row;
    logic [1:0] b_col;
    logic [7:0] b_rdata;
    logic       c_we;
    logic [1:0] c_row, c_col;
    logic [7:0] c_wdata;
    logic       busy, done;

    logic [7:0] a_mem [D1][D2];
    logic [7:0] b_mem [D2][D3];

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;

    matmul_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stall   (stall),
        .a_row   (a_row),
        .a_col   (a_col),
        .a_rdata (a_rdata),
        .b_row   (b_row),
        .b_col   (b_col),
        .b_rdata (b_rdata),
        .c_we    (c_we),
        .c_row   (c_row),
        .c_col   (c_col),
        .c_wdata (c_wdata),
        .busy    (busy),
        .done    (done)
    );

    assign a_rdata = a_mem[a_row][a_col];
    assign b_rdata = (b_col < 2'(D3)) ? b_mem[b_row][b_col] : 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (c_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("c_row", int'(c_row), e.row);
                check("c_col", int'(c_col), e.col);
                check("c_wdata", int'(c_wdata), e.data);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_expected();
        int sum;
        wr_t e;
        for (int i = 0; i < D1; i++) begin
            for (int j = 0; j < D3; j++) begin
                sum = 0;
                for (int k = 0; k < D2; k++) sum += int'(a_mem[i][k]) * int'(b_mem[k][j]);
`ifdef MATMUL_SAT_EN
                e.data = (sum > 255) ? 255 : sum;
`else
                e.data = sum % 256;
`endif
                e.row = i;
                e.col = j;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic load_example();
        int av[8] = '{4, 5, 7, 8, 10, 11, 13, 14};
        int bv[6] = '{5, 6, 7, 8, 9, 10};
        for (int i = 0; i < D1; i++)
            for (int k = 0; k < D2; k++) a_mem[i][k] = 8'(av[i*D2 + k]);
        for (int k = 0; k < D2; k++)
            for (int j = 0; j < D3; j++) b_mem[k][j] = 8'(bv[k*D3 + j]);
    endtask

    task automatic load_const(input int v);
        for (int i = 0; i < D1; i++)
            for (int k = 0; k < D2; k++) a_mem[i][k] = 8'(v);
        for (int k = 0; k < D2; k++)
            for (int j = 0; j < D3; j++) b_mem[k][j] = 8'(v);
    endtask

    // Pulses start for one cycle; s is the cycle number of the first MAC cycle.
    task automatic start_pass(output int s);
        push_expected();
        @(negedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    initial begin
        int s, w0, d0;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        load_example();

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_c_we", int'(c_we), 0);
        check("rst_done", int'(done), 0);
        check("rst_a_row", int'(a_row), 0);
        check("rst_b_col", int'(b_col), 0);
        check("rst_c_row", int'(c_row), 0);
        check("rst_c_wdata", int'(c_wdata), 0);
        #1 rst_n = 1'b1;

        // Example pass with MAC index and timing checks
        w0 = wr_cnt;
        push_expected();
        @(negedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        check("mac0_busy", int'(busy), 1);
        check("mac0_a_col", int'(a_col), 0);
        check("mac0_b_row", int'(b_row), 0);
        #1 start = 1'b0;
        @(negedge clk);
        check("mac1_a_col", int'(a_col), 1);
        check("mac1_b_row", int'(b_row), 1);
        check("mac1_b_col", int'(b_col), 0);
        wait_done(1, 200);
        check("ex_done_latency", done_cyc - s, 36);
        check("ex_writes", wr_cnt - w0, 12);
        check("ex_queue_left", exp_q.size(), 0);
        @(negedge clk);
        check("ex_done_width", int'(done), 0);
        check("ex_idle_busy", int'(busy), 0);

        // Inner-dimension overflow: 15*15*2 = 450
        load_const(15);
        w0 = wr_cnt;
        start_pass(s);
        wait_done(2, 200);
        check("ovf_writes", wr_cnt - w0, 12);
        check("ovf_done_latency", done_cyc - s, 36);
        load_example();

        // Held start: back-to-back passes with one IDLE cycle in between
        w0 = wr_cnt;
        push_expected();
        push_expected();
        @(negedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        wait_done(3, 200);
        check("b2b_first_done", done_cyc - s, 36);
        wait_done(4, 200);
        check("b2b_second_done", done_cyc - s, 74);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("b2b_stays_idle", int'(busy), 0);
        check("b2b_writes", wr_cnt - w0, 24);

        // Stall of 5 cycles across the WRITE of C[1][2] (element 5, cycle s+17)
        w0 = wr_cnt;
        start_pass(s);
        wait_cyc(s + 16);
        stall = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_c_we", int'(c_we), 0);
            check("stall_busy", int'(busy), 1);
        end
        #1 stall = 1'b0;
        wait_done(5, 200);
        check("stall_done_latency", done_cyc - s, 41);
        check("stall_writes", wr_cnt - w0, 12);
        check("stall_queue_left", exp_q.size(), 0);

        // Reset after the third write abandons the pass
        w0 = wr_cnt;
        d0 = done_cnt;
        start_pass(s);
        wait_cyc(s + 9);
        check("rst_mid_writes", wr_cnt - w0, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_c_we", int'(c_we), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_a_row", int'(a_row), 0);
        check("rst_mid_pending", exp_q.size(), 9);
        exp_q.delete();
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_more_writes", wr_cnt - w0, 3);

        w0 = wr_cnt;
        start_pass(s);
        wait_done(d0 + 1, 200);
        check("post_rst_writes", wr_cnt - w0, 12);
        check("post_rst_done_latency", done_cyc - s, 36);
        check("post_rst_queue_left", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 The block SHALL have parameter bitlength, default 8: width of each A, B and C element.
REQ-002 The block SHALL have parameter M1_D1, default 4: rows of A and C.
REQ-003 The block SHALL have parameter M1_D2, default 2: columns of A and rows of B (inner dimension).
REQ-004 The block SHALL have parameter M2_D2, default 3: columns of B and C.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one full C = A x B pass.
- stall  in  1  freeze all state while high.
- a_row  out  clog2(M1_D1)  A read row index.
- a_col  out  clog2(M1_D2)  A read column index.
- a_rdata  in  bitlength  A[a_row][a_col], combinational read.
- b_row  out  clog2(M1_D2)  B read row index.
- b_col  out  clog2(M2_D2)  B read column index.
- b_rdata  in  bitlength  B[b_row][b_col], combinational read.
- c_we  out  1  C write strobe.
- c_row  out  clog2(M1_D1)  C write row index.
- c_col  out  clog2(M2_D2)  C write column index.
- c_wdata  out  bitlength  C element value.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pass-complete pulse.
- Each index port SHALL be at least 1 bit wide.

Function
REQ-006 The block SHALL use a single unsigned multiply-accumulate unit with an accumulator of 2*bitlength+clog2(M1_D2) bits.
REQ-007 The FSM SHALL have exactly four states: IDLE, MAC, WRITE, DONE.
REQ-008 In IDLE with start=1 at a clock edge, the FSM SHALL go to MAC and clear i, j and k to 0; start in any other state SHALL be ignored.
REQ-009 In MAC, the outputs SHALL be a_row=i, a_col=k, b_row=k, b_col=j.
REQ-010 At each MAC edge, acc SHALL load a_rdata*b_rdata when k=0, and acc+a_rdata*b_rdata otherwise.
REQ-011 At each MAC edge, k SHALL increment; when k=M1_D2-1, k SHALL return to 0 and the FSM SHALL go to WRITE.
REQ-012 In WRITE, for exactly one cycle, the outputs SHALL be c_we=1, c_row=i, c_col=j and c_wdata=acc, reduced per REQ-021.
REQ-013 After WRITE, j SHALL increment; on j wrap (M2_D2-1 to 0), i SHALL increment. If (i,j) was (M1_D1-1, M2_D2-1), the FSM SHALL go to DONE; otherwise it SHALL go to MAC.
REQ-014 DONE SHALL assert done=1 for one cycle, then go to IDLE; a start present during DONE SHALL be ignored.
REQ-015 busy SHALL be 1 in MAC, WRITE and DONE, and 0 in IDLE.
REQ-016 C elements SHALL be written in row-major order.
REQ-017 The pass SHALL take exactly M1_D1*M2_D2*(M1_D2+1) cycles, plus one cycle for DONE.
REQ-018 With stall=1, state, counters and acc SHALL hold; c_we and done SHALL be forced to 0. A stalled WRITE or DONE cycle SHALL re-issue when stall falls.
REQ-019 c_we and done SHALL be 0 outside WRITE and DONE respectively; index outputs SHALL be 0 in IDLE.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE; i, j, k and acc SHALL become 0, and all outputs SHALL become 0. Reset mid-pass SHALL abandon the pass with no further c_we, and no done pulse.

Configuration
REQ-021 With macro MATMUL_SAT_EN defined, c_wdata SHALL be acc clamped to 2^bitlength-1. Without MATMUL_SAT_EN, c_wdata SHALL be acc[bitlength-1:0] (modulo truncation).

Verification
REQ-022 Default params, A=[4 5;7 8;10 11;13 14], B=[5 6 7;8 9 10], start pulse -> 12 writes in order: 60,69,78,99,114,129,138,159,180,177,204,231; done exactly 36 cycles after the write pass begins (cycle 37 after start sampled).
REQ-023 M1_D2=2, all A=15, B=15, no macro -> every c_wdata=194. Same stimulus with MATMUL_SAT_EN -> every c_wdata=255.
REQ-024 Hold start=1 continuously -> back-to-back passes. Each pass SHALL begin one cycle after IDLE is re-entered, and the start pulses during busy SHALL be ignored.
REQ-025 Assert stall for 5 cycles during WRITE of C[1][2] -> c_we SHALL be low during the stall. C[1][2]=129 SHALL be written once after release, and done SHALL be delayed by exactly 5 cycles.
REQ-026 Pull rst_n low after the third write -> busy, c_we and done SHALL go to 0 immediately. After release, a new start SHALL produce the full correct 12-write sequence.
